prescaled_updown_counter: RTL and testbench

//  Parametrised tick counter with an integrated prescaler.
//  - Divides clk with an internal PRE_W-bit prescaler.
//  - On each prescaler overflow, steps a CNT_W-bit counter up or down, in wrap or saturate mode.
//  - Supports synchronous clear, synchronous load and a terminal-count pulse.
//  - Drives slow visible counters/displays from the board clock.

---
 rtl/psc_cnt_pkg.sv | 13 +
 rtl/tick_prescaler.sv | 45 ++++
 rtl/prescaled_updown_counter.sv | 120 ++++++++++++
 tb/tb_prescaled_updown_counter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psc_cnt_pkg.sv
// Shared constants for the prescaled up/down counter: the encodings used on
// the up_dn and sat_mode inputs.
package psc_cnt_pkg;

  // Count direction as presented on up_dn
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Limit behaviour as presented on sat_mode
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : psc_cnt_pkg

// File: rtl/tick_prescaler.sv
// Free-running prescaler. It counts enabled clk cycles from 0 to PRE_MAX and
// raises tick combinationally for the whole cycle it sits at PRE_MAX. The
// tick period is therefore PRE_MAX+1 enabled cycles.
module tick_prescaler
  import psc_cnt_pkg::*;
#(
  parameter int               PRE_W   = 23,
  parameter logic [PRE_W-1:0] PRE_MAX = {PRE_W{1'b1}}
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  // Gating with en means that a frozen prescaler never emits a tick, even if it
  // happens to be stopped at the terminal value.
  assign tick = en && (pre_cnt_q == PRE_MAX);

  // Next prescaler value: clear beats wrap, wrap beats increment, else hold
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  // Prescaler state register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule : tick_prescaler

// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down tick counter. A tick_prescaler divides clk; each tick
// steps a CNT_W-bit counter up or down, either wrapping or saturating at the
// limits. A registered tc pulse marks every tick taken at the limit in the
// active direction.
// Optional build macro PSC_STICKY_TC_EN adds a sticky tc_flag output, cleared
// by tc_ack or clr.
module prescaled_updown_counter
  import psc_cnt_pkg::*;
#(
  parameter int               CNT_W   = 4,
  parameter int               PRE_W   = 23,
  parameter logic [PRE_W-1:0] PRE_MAX = {PRE_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [CNT_W-1:0] count,
  output logic             tick,
`ifdef PSC_STICKY_TC_EN
  output logic             tc_flag,
  input  logic             tc_ack,
`endif
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] step_val;
  logic             tc_q;
  logic             tc_d;
  logic             at_limit;
  logic             hold_at_limit;

  tick_prescaler #(
    .PRE_W   (PRE_W),
    .PRE_MAX (PRE_MAX)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .tick  (tick)
  );

  // Value the counter takes on a tick. Wrapping comes for free from the
  // modulo-2^CNT_W arithmetic; saturation just suppresses the step.
  always_comb begin
    at_limit      = (up_dn == DIR_UP) ? (count_q == CNT_MAX) : (count_q == '0);
    hold_at_limit = (sat_mode == MODE_SAT) && at_limit;
    step_val      = count_q;
    if (!hold_at_limit) begin
      step_val = (up_dn == DIR_UP) ? (count_q + 1'b1) : (count_q - 1'b1);
    end
  end

  // Counter and tc next state: clr > load > tick step > hold. tc only fires
  // when the step itself wins the edge.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick) begin
      count_d = step_val;
      tc_d    = at_limit;
    end
  end

  // Counter and tc registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;

`ifdef PSC_STICKY_TC_EN
  logic tc_flag_q;
  logic tc_flag_d;

  // Sticky flag: clr clears, a new tc sets (winning over ack), ack clears
  always_comb begin
    tc_flag_d = tc_flag_q;
    if (clr) begin
      tc_flag_d = 1'b0;
    end else if (tc_d) begin
      tc_flag_d = 1'b1;
    end else if (tc_ack) begin
      tc_flag_d = 1'b0;
    end
  end

  // Sticky flag register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_flag_q <= 1'b0;
    end else begin
      tc_flag_q <= tc_flag_d;
    end
  end

  assign tc_flag = tc_flag_q;
`endif

endmodule : prescaled_updown_counter

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter with PRE_W=2, PRE_MAX=3, CNT_W=4.
// Inputs change on the falling edge; tick is sampled 1 time unit after the
// inputs settle, registered outputs on the following falling edge.
module tb_prescaled_updown_counter;

  localparam int              CNT_W   = 4;
  localparam int              PRE_W   = 2;
  localparam logic [PRE_W-1:0] PRE_MAX = 2'd3;
  localparam int              PRE_TOP = 3;
  localparam int              CMAX    = 15;

  logic             clk;
  logic             reset;
  logic             en;
  logic             clr;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             up_dn;
  logic             sat_mode;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             tc;
`ifdef PSC_STICKY_TC_EN
  logic             tc_flag;
  logic             tc_ack;
`endif

  prescaled_updown_counter #(
    .CNT_W   (CNT_W),
    .PRE_W   (PRE_W),
    .PRE_MAX (PRE_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .up_dn    (up_dn),
    .sat_mode (sat_mode),
    .count    (count),
    .tick     (tick),
`ifdef PSC_STICKY_TC_EN
    .tc_flag  (tc_flag),
    .tc_ack   (tc_ack),
`endif
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: prescaler position, counter value, tc and flag
  int m_pre;
  int m_cnt;
  bit m_tc;
  bit m_flag;

  int vectors;
  int miscompares;
  int cyc;

  typedef struct {
    bit en;
    bit clr;
    bit load;
    int lv;
    bit up;
    bit sat;
    bit e_tick;
    int e_cnt;
    bit e_tc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pre  = 0;
    m_cnt  = 0;
    m_tc   = 0;
    m_flag = 0;
  endtask

  // One clock of stimulus, checked against the reference model
  task automatic cycle(input bit e, input bit c, input bit l, input int lv,
                       input bit u, input bit s, input bit a,
                       output logic t_o, output logic [CNT_W-1:0] c_o, output logic tc_o);
    bit m_tick;
    bit lim;
    en       = e;
    clr      = c;
    load     = l;
    load_val = lv[CNT_W-1:0];
    up_dn    = u;
    sat_mode = s;
`ifdef PSC_STICKY_TC_EN
    tc_ack   = a;
`endif
    #1;
    m_tick = e && (m_pre == PRE_TOP);
    t_o = tick;
    check("tick", tick, m_tick);
    @(posedge clk);
    if (c || m_tick) m_pre = 0;
    else if (e)      m_pre = m_pre + 1;
    lim = u ? (m_cnt == CMAX) : (m_cnt == 0);
    if (c) begin
      m_cnt = 0;
      m_tc  = 0;
    end else if (l) begin
      m_cnt = lv % 16;
      m_tc  = 0;
    end else if (m_tick) begin
      m_tc = lim;
      if (!(s && lim)) m_cnt = u ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
    end else begin
      m_tc = 0;
    end
    if (c)         m_flag = 0;
    else if (m_tc) m_flag = 1;
    else if (a)    m_flag = 0;
    @(negedge clk);
    c_o  = count;
    tc_o = tc;
    check("count", count, m_cnt);
    check("tc", tc, m_tc);
`ifdef PSC_STICKY_TC_EN
    check("tc_flag", tc_flag, m_flag);
`endif
    cyc++;
    $display("cyc %0d en=%0b clr=%0b load=%0b lv=%0d up=%0b sat=%0b ack=%0b | tick=%0b count=%0d tc=%0b",
             cyc, e, c, l, lv, u, s, a, t_o, c_o, tc_o);
  endtask

  task automatic add(input bit e, input bit c, input bit l, input int lv, input bit u,
                     input bit s, input bit et, input int ec, input bit etc, input int n);
    vec_t v;
    v.en = e; v.clr = c; v.load = l; v.lv = lv; v.up = u; v.sat = s;
    v.e_tick = et; v.e_cnt = ec; v.e_tc = etc;
    repeat (n) tbl.push_back(v);
  endtask

  // Runs enabled up-count cycles until a tick is seen; optionally asserts
  // tc_ack exactly on the tick cycle.
  task automatic run_to_tick(input bit ack_on_tick);
    logic t, tcv;
    logic [CNT_W-1:0] cv;
    bit got;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      cycle(1, 0, 0, 0, 1, 0, ack_on_tick && (m_pre == PRE_TOP), t, cv, tcv);
      if (t === 1'b1) got = 1;
    end
    check("tick_reached", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t, tcv;
    logic [CNT_W-1:0] cv;
    int tc_seen;
    int ticks_seen;

    vectors = 0; miscompares = 0; cyc = 0;
    reset = 1'b1; en = 0; clr = 0; load = 0; load_val = '0; up_dn = 1; sat_mode = 0;
`ifdef PSC_STICKY_TC_EN
    tc_ack = 0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_tc", tc, 0);
    check("reset_tick", tick, 0);
`ifdef PSC_STICKY_TC_EN
    check("reset_flag", tc_flag, 0);
`endif
    reset = 1'b0;

    // Up/wrap: 64 enabled clocks give 16 ticks, count 1..15,0 and one tc
    tc_seen = 0; ticks_seen = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1, 0, 0, 0, 1, 0, 0, t, cv, tcv);
      tc_seen    += (tcv === 1'b1) ? 1 : 0;
      ticks_seen += (t === 1'b1) ? 1 : 0;
    end
    check("wrap_tc_pulses", tc_seen, 1);
    check("wrap_ticks", ticks_seen, 16);
    check("wrap_final_count", count, 0);

    // Freeze: 6 enabled clocks leave pre=2, count=1; 10 frozen clocks hold
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1, 0, 0, t, cv, tcv);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 1, 0, 0, t, cv, tcv);
      check("freeze_count", cv, 1);
      check("freeze_tick", t, 0);
    end
    cycle(1, 0, 0, 0, 1, 0, 0, t, cv, tcv);
    check("resume_no_tick_yet", t, 0);
    cycle(1, 0, 0, 0, 1, 0, 0, t, cv, tcv);
    check("resume_tick", t, 1);
    check("resume_count", cv, 2);

    // Realign: clr puts prescaler and counter at 0
    cycle(0, 1, 0, 0, 1, 0, 0, t, cv, tcv);

    // Table: down/saturate from 2, then clr-vs-load-vs-tick, then lone load
    //  en clr load lv up sat | tick count tc | repeat
    add(0, 0, 1,  2, 0, 1,   0,  2, 0, 1);
    add(1, 0, 0,  0, 0, 1,   0,  2, 0, 3);
    add(1, 0, 0,  0, 0, 1,   1,  1, 0, 1);
    add(1, 0, 0,  0, 0, 1,   0,  1, 0, 3);
    add(1, 0, 0,  0, 0, 1,   1,  0, 0, 1);
    add(1, 0, 0,  0, 0, 1,   0,  0, 0, 3);
    add(1, 0, 0,  0, 0, 1,   1,  0, 1, 1);
    add(1, 0, 0,  0, 0, 1,   0,  0, 0, 3);
    add(1, 0, 0,  0, 0, 1,   1,  0, 1, 1);
    add(1, 0, 1, 15, 1, 0,   0, 15, 0, 1);
    add(1, 0, 0,  0, 1, 0,   0, 15, 0, 2);
    add(1, 1, 1,  9, 1, 0,   1,  0, 0, 1);
    add(1, 0, 0,  0, 1, 0,   0,  0, 0, 3);
    add(1, 0, 1,  9, 1, 0,   1,  9, 0, 1);
    add(1, 0, 0,  0, 1, 0,   0,  9, 0, 3);
    add(1, 0, 0,  0, 1, 0,   1, 10, 0, 1);
    foreach (tbl[i]) begin
      cycle(tbl[i].en, tbl[i].clr, tbl[i].load, tbl[i].lv, tbl[i].up, tbl[i].sat, 0, t, cv, tcv);
      check("tbl_tick", t, tbl[i].e_tick);
      check("tbl_count", cv, tbl[i].e_cnt);
      check("tbl_tc", tcv, tbl[i].e_tc);
    end

    // Async reset mid-period with pre=2, count=7
    cycle(1, 0, 1, 7, 1, 0, 0, t, cv, tcv);
    cycle(1, 0, 0, 0, 1, 0, 0, t, cv, tcv);
    check("prereset_count", cv, 7);
    reset = 1'b1;
    #1;
    check("async_reset_count", count, 0);
    check("async_reset_tc", tc, 0);
    check("async_reset_tick", tick, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // Prescaler restarts from 0: the 4th enabled clock ticks
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 0, 0, t, cv, tcv);
    check("post_reset_count", cv, 1);

`ifdef PSC_STICKY_TC_EN
    // Sticky flag: set by tc, held, lone ack clears, ack with new tc keeps 1
    cycle(0, 0, 1, 15, 1, 0, 0, t, cv, tcv);
    run_to_tick(0);
    check("flag_set", tc_flag, 1);
    cycle(0, 0, 0, 0, 1, 0, 0, t, cv, tcv);
    check("flag_held", tc_flag, 1);
    cycle(0, 0, 1, 15, 1, 0, 0, t, cv, tcv);
    check("flag_held_load", tc_flag, 1);
    run_to_tick(1);
    check("flag_set_beats_ack", tc_flag, 1);
    cycle(0, 0, 0, 0, 1, 0, 1, t, cv, tcv);
    check("flag_ack_clears", tc_flag, 0);
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 32) == 0, ($urandom % 16) == 0,
            int'($urandom % 16), ($urandom % 4) != 0, $urandom % 2, ($urandom % 4) == 0,
            t, cv, tcv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_prescaled_updown_counter
